// File: rtl/fc_layer_engine_if.sv
// Bus bundle for fc_layer_engine. It carries the start/busy/done handshake, the
// ROM and RAM ports, the external MultAdder operands and result, and RAM write-back.
//   master : the engine side. It drives addresses, operands, write-back and status.
//   slave  : the environment side. It drives start, memory read data and the
//            MultAdder result.
interface fc_layer_engine_if #(
   parameter int unsigned LANES = 128
);
   localparam int unsigned W = LANES * 8;

   logic          start;
   logic [W-1:0]  data_from_rom;
   logic [W-1:0]  data_from_ram;
   logic [14:0]   data_from_MultAdder;
   logic          overflow_from_MultAdder;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [31:0]   addr_to_rom;
   logic [31:0]   addr_to_ram;
   logic [W-1:0]  opr1_to_MultAdder;
   logic [W-1:0]  opr2_to_MultAdder;
   logic [W-1:0]  data_to_ram;
   logic          ram_we;

   modport master (
      input  start, data_from_rom, data_from_ram, data_from_MultAdder, overflow_from_MultAdder,
      output busy, done, overflow, addr_to_rom, addr_to_ram,
             opr1_to_MultAdder, opr2_to_MultAdder, data_to_ram, ram_we
   );

   modport slave (
      output start, data_from_rom, data_from_ram, data_from_MultAdder, overflow_from_MultAdder,
      input  busy, done, overflow, addr_to_rom, addr_to_ram,
             opr1_to_MultAdder, opr2_to_MultAdder, data_to_ram, ram_we
   );
endinterface

// File: rtl/fc_layer_engine.sv
// fc_layer_engine: a fully-connected layer sequencer.
// For each output row it computes sum_c(W[r][c] . a[c]) + bias[r]. It accumulates
// in the 15-bit Float8 format (sign, 4-bit exponent, 10-bit mantissa), and packs
// the top byte of each row result into LANES-byte words written back to RAM.
// Ports: clk, iRst_n (synchronous, active-low), io_bus (fc_layer_engine_if.master).
// Optional feature: define FC_RELU_EN so that negative result bytes are stored as 8'h00.
module fc_layer_engine #(
   parameter int unsigned LANES     = 128,
   parameter int unsigned IN_CHUNKS = 8,
   parameter int unsigned OUT_ROWS  = 128,
   parameter logic [31:0] ROM_BASE  = 32'h0000_0000,
   parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
   parameter logic [31:0] BIAS_BASE = 32'h0000_2000,
   parameter logic [31:0] OUT_BASE  = 32'h0000_3000
) (
   input logic                clk,
   input logic                iRst_n,
   fc_layer_engine_if.master  io_bus
);
   localparam int unsigned W      = LANES * 8;
   localparam int unsigned ROW_W  = $clog2(OUT_ROWS + 1);
   localparam int unsigned COL_W  = (IN_CHUNKS > 1) ? $clog2(IN_CHUNKS) : 1;
   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned MAG_W  = 26;

   typedef enum logic [3:0] {
      S_IDLE, S_B_REQ, S_B_GET, S_R_INIT, S_REQ, S_LOAD,
      S_ACC, S_ACCW, S_BIAS, S_STORE, S_FLUSH, S_DONE
   } state_t;

   state_t              r_state;
   logic [ROW_W-1:0]    r_row;
   logic [COL_W-1:0]    r_col;
   logic [LANE_W-1:0]   r_lane;
   logic [31:0]         r_blk;
   logic [31:0]         r_woff;
   logic [W-1:0]        r_bias;
   logic [W-1:0]        r_buf;
   logic [14:0]         r_sum;
   logic [14:0]         r_add_a;
   logic [14:0]         r_add_b;
   logic                r_busy;
   logic                r_done;
   logic                r_ovf;
   logic [31:0]         r_addr_rom;
   logic [31:0]         r_addr_ram;
   logic [W-1:0]        r_opr1;
   logic [W-1:0]        r_opr2;
   logic [W-1:0]        r_data_out;
   logic                r_we;

   logic [14:0]         w_add_sum;
   logic                w_add_ovf;
   logic [7:0]          w_byte;
   logic [7:0]          w_bias_byte;
   logic [W-1:0]        w_buf_next;
   logic                w_flush;

   // Magnitude of a 15-bit Float8 value as a fixed-point integer (exp 0 = subnormal)
   function automatic logic [MAG_W-1:0] f_decode(input logic [14:0] x);
      if (x[13:10] == 4'd0) return MAG_W'(x[9:0]);
      return MAG_W'({1'b1, x[9:0]}) << (x[13:10] - 4'd1);
   endfunction

   // Float8Adder: add the magnitudes exactly, then renormalise with mantissa truncation.
   // An exponent above 15 raises overflow; the stored exponent then wraps.
   logic [MAG_W-1:0] w_mag_a, w_mag_b, w_mag, w_norm;
   logic             w_neg;
   logic [4:0]       w_msb, w_exp;
   logic [9:0]       w_man;

   always_comb begin
      w_mag_a = f_decode(r_add_a);
      w_mag_b = f_decode(r_add_b);
      w_mag   = '0;
      w_neg   = 1'b0;
      w_msb   = '0;
      w_exp   = '0;
      w_man   = '0;
      w_norm  = '0;
      if (r_add_a[14] == r_add_b[14]) begin
         w_mag = w_mag_a + w_mag_b;
         w_neg = r_add_a[14];
      end else if (w_mag_a >= w_mag_b) begin
         w_mag = w_mag_a - w_mag_b;
         w_neg = r_add_a[14];
      end else begin
         w_mag = w_mag_b - w_mag_a;
         w_neg = r_add_b[14];
      end
      if (w_mag == '0) w_neg = 1'b0;
      for (int i = 0; i < int'(MAG_W); i++) begin
         if (w_mag[i]) w_msb = 5'(i);
      end
      if (w_mag[MAG_W-1:10] == '0) begin
         w_man = w_mag[9:0];
      end else begin
         w_exp  = w_msb - 5'd9;
         w_norm = w_mag >> (w_msb - 5'd10);
         w_man  = w_norm[9:0];
      end
      w_add_ovf = w_exp[4];
      w_add_sum = {w_neg, w_exp[3:0], w_man};
   end

   // Result byte for the current row
`ifdef FC_RELU_EN
   assign w_byte = w_add_sum[14] ? 8'h00 : w_add_sum[14:7];
`else
   assign w_byte = w_add_sum[14:7];
`endif

   assign w_bias_byte = r_bias[r_lane*8 +: 8];
   assign w_flush     = (r_lane == LANE_W'(LANES - 1)) || (r_row == ROW_W'(OUT_ROWS - 1));

   // Output buffer with the current row's byte merged in, so STORE can flush it directly
   always_comb begin
      w_buf_next = r_buf;
      w_buf_next[r_lane*8 +: 8] = w_byte;
   end

   // Sequencer. Address registers are loaded on entry to the request state, so
   // read data returns in the following state.
   always_ff @(posedge clk) begin
      if (!iRst_n) begin
         r_state    <= S_IDLE;
         r_row      <= '0;
         r_col      <= '0;
         r_lane     <= '0;
         r_blk      <= '0;
         r_woff     <= '0;
         r_bias     <= '0;
         r_buf      <= '0;
         r_sum      <= '0;
         r_add_a    <= '0;
         r_add_b    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ovf      <= 1'b0;
         r_addr_rom <= '0;
         r_addr_ram <= '0;
         r_opr1     <= '0;
         r_opr2     <= '0;
         r_data_out <= '0;
         r_we       <= 1'b0;
      end else begin
         r_we <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (io_bus.start) begin
                  r_ovf      <= 1'b0;
                  r_done     <= 1'b0;
                  r_buf      <= '0;
                  r_row      <= '0;
                  r_col      <= '0;
                  r_lane     <= '0;
                  r_blk      <= '0;
                  r_woff     <= '0;
                  r_busy     <= 1'b1;
                  r_addr_rom <= BIAS_BASE;
                  r_state    <= S_B_REQ;
               end
            end
            S_B_REQ: r_state <= S_B_GET;
            S_B_GET: begin
               r_bias  <= io_bus.data_from_rom;
               r_state <= S_R_INIT;
            end
            S_R_INIT: begin
               r_sum      <= '0;
               r_col      <= '0;
               r_addr_rom <= ROM_BASE + r_woff;
               r_addr_ram <= RAM_BASE;
               r_state    <= S_REQ;
            end
            S_REQ: r_state <= S_LOAD;
            S_LOAD: begin
               r_opr1  <= io_bus.data_from_ram;
               r_opr2  <= io_bus.data_from_rom;
               r_state <= S_ACC;
            end
            S_ACC: begin
               r_add_a <= r_sum;
               r_add_b <= io_bus.data_from_MultAdder;
               r_ovf   <= r_ovf | io_bus.overflow_from_MultAdder;
               r_state <= S_ACCW;
            end
            S_ACCW: begin
               r_sum  <= w_add_sum;
               r_ovf  <= r_ovf | w_add_ovf;
               r_woff <= r_woff + 32'd1;
               if (r_col == COL_W'(IN_CHUNKS - 1)) begin
                  r_state <= S_BIAS;
               end else begin
                  r_col      <= r_col + COL_W'(1);
                  r_addr_rom <= ROM_BASE + r_woff + 32'd1;
                  r_addr_ram <= RAM_BASE + 32'(r_col) + 32'd1;
                  r_state    <= S_REQ;
               end
            end
            S_BIAS: begin
               r_add_a <= r_sum;
               r_add_b <= {w_bias_byte, 7'b0};
               r_state <= S_STORE;
            end
            S_STORE: begin
               r_ovf  <= r_ovf | w_add_ovf;
               r_buf  <= w_buf_next;
               r_row  <= r_row + ROW_W'(1);
               r_lane <= (r_lane == LANE_W'(LANES - 1)) ? '0 : r_lane + LANE_W'(1);
               if (w_flush) begin
                  r_addr_ram <= OUT_BASE + r_blk;
                  r_data_out <= w_buf_next;
                  r_we       <= 1'b1;
                  r_state    <= S_FLUSH;
               end else begin
                  r_state <= S_R_INIT;
               end
            end
            S_FLUSH: begin
               r_buf <= '0;
               if (r_row == ROW_W'(OUT_ROWS)) begin
                  r_state <= S_DONE;
               end else begin
                  r_blk      <= r_blk + 32'd1;
                  r_addr_rom <= BIAS_BASE + r_blk + 32'd1;
                  r_state    <= S_B_REQ;
               end
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign io_bus.busy              = r_busy;
   assign io_bus.done              = r_done;
   assign io_bus.overflow          = r_ovf;
   assign io_bus.addr_to_rom       = r_addr_rom;
   assign io_bus.addr_to_ram       = r_addr_ram;
   assign io_bus.opr1_to_MultAdder = r_opr1;
   assign io_bus.opr2_to_MultAdder = r_opr2;
   assign io_bus.data_to_ram       = r_data_out;
   assign io_bus.ram_we            = r_we;
endmodule

// File: doc/fc_layer_engine.md
# fc_layer_engine

Parametrised fully-connected layer sequencer for the TPU datapath. It computes `out[r] = sum_c(W[r][c] · a[c]) + bias[r]` for `OUT_ROWS` rows. Each row takes `IN_CHUNKS` chunks of `LANES` Float8 products through the external MultAdder. Accumulation uses an internal `Float8Adder` in 15-bit format. Results are packed `LANES` bytes per RAM word and written back with a write strobe. It replaces the fixed 128×8 layer block with a start/done handshake, multi-block output, proper write-back and optional ReLU.

## Interface

**Parameters**
- `LANES`, 128: bytes per memory word and per MultAdder operand.
- `IN_CHUNKS`, 8: input words per row, so input length = `LANES·IN_CHUNKS`.
- `OUT_ROWS`, 128: number of output neurons, ≥1.
- `ROM_BASE`, 32'h0000_0000: weight base. Row r, chunk c is at `ROM_BASE + r·IN_CHUNKS + c`.
- `RAM_BASE`, 32'h0000_1000: activation base. Chunk c is at `RAM_BASE + c`.
- `BIAS_BASE`, 32'h0000_2000: bias words. Block b is at `BIAS_BASE + b`.
- `OUT_BASE`, 32'h0000_3000: output words. Block b is at `OUT_BASE + b`.

**Ports**
- `clk`, in, 1: clock.
- `iRst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: run request, sampled only in IDLE.
- `data_from_rom`, in, LANES·8: ROM read data, valid 1 cycle after `addr_to_rom`.
- `data_from_ram`, in, LANES·8: RAM read data, valid 1 cycle after `addr_to_ram`.
- `data_from_MultAdder`, in, 15: combinational dot product of the current operands.
- `overflow_from_MultAdder`, in, 1: overflow flag for that dot product.
- `busy`, out, 1: high from start acceptance until DONE.
- `done`, out, 1: held high from DONE until the next accepted start.
- `overflow`, out, 1: sticky OR of all overflows for the current run.
- `addr_to_rom`, out, 32: ROM address.
- `addr_to_ram`, out, 32: RAM address, used for both read and write.
- `opr1_to_MultAdder`, out, LANES·8: activation operand.
- `opr2_to_MultAdder`, out, LANES·8: weight operand.
- `data_to_ram`, out, LANES·8: output word; byte i = row `b·LANES+i`.
- `ram_we`, out, 1: one-cycle write strobe for `data_to_ram` at `addr_to_ram`.

## Operation

- **Blocks:** NB = ceil(OUT_ROWS/LANES). Row r belongs to block r/LANES, lane r%LANES.
- **IDLE:**
  - On `start`: clear `overflow`, `done` and the output buffer, zero the row/col counters, set `busy`, go to B_REQ.
- **B_REQ:**
  - Drive `addr_to_rom = BIAS_BASE + b`.
- **B_GET:**
  - Latch `data_from_rom` into the bias register.
- **R_INIT:**
  - Set sum = 0 and col = 0.
- **REQ:**
  - Drive `addr_to_rom` to the weight address and `addr_to_ram` to the activation address.
- **LOAD:**
  - Set `opr1 <= data_from_ram` and `opr2 <= data_from_rom`.
- **ACC:**
  - Set adder inputs to sum and `data_from_MultAdder`.
  - `overflow |= overflow_from_MultAdder`.
- **ACCW:**
  - Set sum <= adder result and `overflow |= adder overflow`.
  - If col == IN_CHUNKS−1, go to BIAS. Otherwise col++ and go to REQ.
- **BIAS:**
  - Adder inputs are sum and `{bias byte[lane], 7'b0}`.
- **STORE:**
  - Set `overflow |= adder overflow`.
  - Write byte = adder result[14:7] into the buffer lane (after ReLU, see Configuration).
  - Then row++.
  - If row%LANES == 0 or row == OUT_ROWS, go to FLUSH. Otherwise go to R_INIT.
- **FLUSH:**
  - Drive `addr_to_ram = OUT_BASE + b`, `data_to_ram` = buffer and `ram_we = 1` for exactly this cycle.
  - Clear the buffer.
  - If row == OUT_ROWS, go to DONE. Otherwise b++ and go to B_REQ.
- **DONE:**
  - `done = 1`, `busy = 0`, then return to IDLE.
- **Partial last block:** unused lanes are written as 8'h00.
- **Arithmetic:** all accumulation is 15-bit Float8 via `Float8Adder`. There is no saturation; overflow is only flagged.

## Timing

- **Reset values:** all outputs 0, including addresses, operands, `data_to_ram`, `ram_we`, `busy`, `done` and `overflow`. State is IDLE.
- **Reset mid-run:** abort immediately to IDLE with reset values. No partial `ram_we` is issued.
- **Start handling:** `start` while busy is ignored. `start` in the same cycle as reset loses to reset.
- **Per-row cost:** 1 + 4·IN_CHUNKS + 2 cycles.
- **Per-block overhead:** 3 cycles (B_REQ, B_GET, FLUSH).
- **Total latency:** from the `start` edge, `done` rises after `NB·3 + OUT_ROWS·(4·IN_CHUNKS+3) + 1` cycles. With defaults this is 4484.
- **Output stability:** `data_to_ram` and `addr_to_ram` are stable during the `ram_we` cycle only. Outside that cycle `data_to_ram` holds its last value.

## Configuration

- `FC_RELU_EN` defined: in STORE, a result byte with bit 7 = 1 (negative) is stored as 8'h00.
- `FC_RELU_EN` undefined: the byte is stored unchanged.

## Test plan

- **Defaults, all-zero stimulus:** all memory and MultAdder results = 0, one start pulse. Expect exactly one `ram_we` at `addr_to_ram` 32'h3000 with data all 0, `done` rising 4484 cycles after start, `overflow = 0`.
- **OUT_ROWS=130, LANES=128:** expect two `ram_we` pulses, at 32'h3000 and 32'h3001. The second word has lanes 2..127 = 0. `addr_to_rom` shows 32'h2000, then later 32'h2001.
- **Overflow stickiness:** pulse `overflow_from_MultAdder` for one ACC cycle in row 5. Expect `overflow` to stay 1 to `done`. A new `start` clears it to 0.
- **ReLU:** MultAdder result 15'h4400 (negative) for row 0, bias 0. With `FC_RELU_EN`, lane 0 = 8'h00. Without it, lane 0 = 8'h88.
- **Busy start:** a `start` pulse mid-run does not change latency or addresses.
- **Reset mid-run:** deassert `iRst_n` during row 3 accumulation. Expect all outputs 0 the next cycle and no `ram_we`. A later `start` completes normally.
